// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline hazard/sequencing controller:
// FSM state encoding, forwarding select codes and the PC register index.
package pipeline_ctrl_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // The PC lives in r15 and is never a forwarding target.
  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Data-memory handshake between the Memory stage and the pipeline controller.
// master = datapath/memory side, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
  logic MemReqM;
  logic MemReadyM;
  logic MemTimeout;
  logic MemErr;

  modport master (output MemReqM, output MemReadyM, input MemTimeout, input MemErr);
  modport slave  (input MemReqM, input MemReadyM, output MemTimeout, output MemErr);
endinterface

// File: rtl/pipeline_fwd_unit.sv
// Forwarding select for one Execute operand. Memory stage result has
// priority over Writeback; r15 (PC) is never forwarded.
module pipeline_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] ra,
  input  logic [3:0] wa_m,
  input  logic [3:0] wa_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  // Priority compare: M, then W, else register file.
  always_comb begin
    fwd_sel = FWD_RF;
    if (ra != PC_REG) begin
      if (reg_write_m && (wa_m == ra))      fwd_sel = FWD_M;
      else if (reg_write_w && (wa_w == ra)) fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: forwarding selects,
// load-use / branch stalls and flushes, and a memory-wait FSM with timeout.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating StallCnt/FlushCnt.
//
// state | meaning
// IDLE  | no outstanding data access, normal hazard handling
// WAIT  | data access in Memory waiting for MemReadyM, pipeline frozen
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TCNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  pipeline_ctrl_if.slave mem,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
`ifdef PIPE_PERF_CNT_EN
  output logic       FlushW,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`else
  output logic       FlushW
`endif
);

  localparam logic [TCNT_W-1:0] TIMEOUT_VAL = TCNT_W'(MEM_TIMEOUT);

  logic [0:0]        state;
  logic [TCNT_W-1:0] cnt;
  logic              mem_err;
  logic              expire;
  logic              memstall;
  logic              ldr_stall;
  logic              pc_wr_pending_f;

  pipeline_fwd_unit u_fwd_a (
    .ra          (RA1E),
    .wa_m        (WA3M),
    .wa_w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  pipeline_fwd_unit u_fwd_b (
    .ra          (RA2E),
    .wa_m        (WA3M),
    .wa_w        (WA3W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  // Timeout and memory-stall terms; reset forces the stall low immediately,
  // so an asserted reset mid-wait releases the pipeline without a clock.
  always_comb begin
    expire    = (state == ST_WAIT) && (cnt == TIMEOUT_VAL);
    memstall  = reset &&
                (((state == ST_IDLE) && mem.MemReqM && !mem.MemReadyM) ||
                 ((state == ST_WAIT) && !mem.MemReadyM && !expire));
    ldr_stall       = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    pc_wr_pending_f = PCSrcD || PCSrcE || PCSrcM;
  end

  // Stall/flush outputs: a memory stall freezes everything and bubbles W.
  always_comb begin
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = ldr_stall || pc_wr_pending_f;
      StallD = ldr_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = pc_wr_pending_f || PCSrcW || BranchTakenE;
      FlushE = ldr_stall || BranchTakenE;
      FlushW = 1'b0;
    end
  end

  assign mem.MemTimeout = expire;
  assign mem.MemErr     = mem_err;

  // Memory-wait FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (expire) mem_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (mem.MemReqM && !mem.MemReadyM) begin
            state <= ST_WAIT;
            cnt   <= TCNT_W'(1);
          end
        end
        default: begin
          if (mem.MemReadyM || expire) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TCNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 32'd1;
      if ((FlushD || FlushE || FlushW) && (FlushCnt != 32'hFFFF_FFFF))
        FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: forwarding, hazard stalls/flushes,
// memory wait, timeout and asynchronous reset during a wait.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_ctrl_if mem_if ();

  pipeline_ctrl #(.MEM_TIMEOUT(16), .TCNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .mem          (mem_if),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
`ifdef PIPE_PERF_CNT_EN
    .FlushW       (FlushW),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
`else
    .FlushW       (FlushW)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0;
    mem_if.MemReqM = 1'b0; mem_if.MemReadyM = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    step(); step();
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0) begin
      errors++;
      $display("FAIL reset_stall_flush got=%b exp=0000000",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    checks++;
    if ({mem_if.MemTimeout, mem_if.MemErr, ForwardAE, ForwardBE} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mem_fwd got=%b exp=000000",
               {mem_if.MemTimeout, mem_if.MemErr, ForwardAE, ForwardBE});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1; RA1E = 4'd3;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_priority got=%b exp=10", ForwardAE);
    end
    RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_pc_never got=%b exp=00", ForwardAE);
    end
    WA3M = 4'd7; WA3W = 4'd9; RA1E = 4'd9; RA2E = 4'd7;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin
      errors++; $display("FAIL fwd_a_w_b_m got=%b exp=0110", {ForwardAE, ForwardBE});
    end
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL fwd_no_write got=%b exp=0000", {ForwardAE, ForwardBE});
    end
    RegWriteW = 1'b1; RA2E = 4'd9;
    #1;
    checks++;
    if (ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_b_w got=%b exp=01", ForwardBE);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1100010) begin
      errors++;
      $display("FAIL ldr_stall got=%b exp=1100010",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    step();
    RA2D = 4'd6;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL ldr_released got=%b exp=000", {StallF, StallD, FlushE});
    end
  endtask

  task automatic test_branch_pc();
    clear_inputs();
    BranchTakenE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      errors++; $display("FAIL branch got=%b exp=0011", {StallF, StallD, FlushD, FlushE});
    end
    clear_inputs();
    PCSrcD = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1010) begin
      errors++; $display("FAIL pcsrc_d got=%b exp=1010", {StallF, StallD, FlushD, FlushE});
    end
    clear_inputs();
    PCSrcW = 1'b1;
    #1;
    checks++;
    if ({StallF, FlushD, FlushE} !== 3'b010) begin
      errors++; $display("FAIL pcsrc_w got=%b exp=010", {StallF, FlushD, FlushE});
    end
    clear_inputs();
  endtask

  task automatic test_zero_cycle();
    clear_inputs();
    step();
    mem_if.MemReqM = 1'b1; mem_if.MemReadyM = 1'b1;
    #1;
    checks++;
    if ({StallF, StallM, FlushW} !== 3'b000) begin
      errors++; $display("FAIL zero_cycle got=%b exp=000", {StallF, StallM, FlushW});
    end
    step();
    mem_if.MemReqM = 1'b0; mem_if.MemReadyM = 1'b0;
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL zero_cycle_after got=%b exp=0", StallM);
    end
  endtask

  // Ready arrives in cycle 3 after the request: exactly 3 stall cycles.
  task automatic test_mem_wait();
    int stalls = 0;
    int bad_pattern = 0;
    clear_inputs();
    step();
    for (int i = 0; i < 8; i++) begin
      mem_if.MemReqM   = (i <= 3);
      mem_if.MemReadyM = (i == 3);
      #1;
      if (StallM) stalls++;
      if ({StallF, StallD, StallE, StallM, FlushW} != {5{(i < 3)}}) bad_pattern++;
      step();
    end
    checks++;
    if (stalls !== 3) begin
      errors++; $display("FAIL mem_wait_cycles got=%0d exp=3", stalls);
    end
    checks++;
    if (bad_pattern !== 0) begin
      errors++; $display("FAIL mem_wait_pattern got=%0d bad cycles exp=0", bad_pattern);
    end
    checks++;
    if (mem_if.MemErr !== 1'b0) begin
      errors++; $display("FAIL mem_wait_err got=%b exp=0", mem_if.MemErr);
    end
    // Memory stall dominates a coincident load-use hazard.
    clear_inputs();
    MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    mem_if.MemReqM = 1'b1;
    #1;
    checks++;
    if ({StallE, FlushD, FlushE, FlushW} !== 4'b1001) begin
      errors++; $display("FAIL memstall_dominates got=%b exp=1001", {StallE, FlushD, FlushE, FlushW});
    end
    mem_if.MemReadyM = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int found = 0;
    int pulse_stall = 1;
    clear_inputs();
    mem_if.MemReqM = 1'b1;
    for (int i = 0; i < 40 && found == 0; i++) begin
      #1;
      if (mem_if.MemTimeout) begin
        found = 1;
        pulse_stall = StallM;
      end else if (StallM) begin
        stalls++;
      end
      step();
    end
    mem_if.MemReqM = 1'b0;
    checks++;
    if (found !== 1) begin
      errors++; $display("FAIL timeout_seen got=%0d exp=1", found);
    end
    checks++;
    if (stalls !== 16) begin
      errors++; $display("FAIL timeout_stalls got=%0d exp=16", stalls);
    end
    checks++;
    if (pulse_stall !== 0) begin
      errors++; $display("FAIL timeout_release got=%0d exp=0", pulse_stall);
    end
    #1;
    checks++;
    if (mem_if.MemTimeout !== 1'b0) begin
      errors++; $display("FAIL timeout_one_pulse got=%b exp=0", mem_if.MemTimeout);
    end
    step(); step(); step();
    checks++;
    if (mem_if.MemErr !== 1'b1) begin
      errors++; $display("FAIL memerr_sticky got=%b exp=1", mem_if.MemErr);
    end
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    mem_if.MemReqM = 1'b1;
    step(); step();
    #1;
    checks++;
    if (StallF !== 1'b1) begin
      errors++; $display("FAIL wait_before_reset got=%b exp=1", StallF);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushW} !== 5'b0) begin
      errors++;
      $display("FAIL reset_in_wait_stall got=%b exp=00000", {StallF, StallD, StallE, StallM, FlushW});
    end
    checks++;
    if ({mem_if.MemErr, mem_if.MemTimeout} !== 2'b00) begin
      errors++; $display("FAIL reset_in_wait_err got=%b exp=00", {mem_if.MemErr, mem_if.MemTimeout});
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", StallCnt, FlushCnt);
    end
`endif
    clear_inputs();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_pc();
    test_zero_cycle();
    test_mem_wait();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipelined core. Drives stall/flush enables of the F/D/E/M/W pipeline registers and forwarding selects for the Execute operands. Owns a small FSM that freezes the pipeline while a data-memory access in Memory waits for its ready handshake, with a timeout guard. Sits beside the datapath, fed by register addresses and control bits from each stage.

## Interface
- MEM_TIMEOUT, default 16: max wait cycles for one memory access before forced release
- TCNT_W, default 5: width of timeout counter, must satisfy 2^TCNT_W > MEM_TIMEOUT
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4  source registers in Decode
- RA1E, RA2E  in  4  source registers in Execute
- WA3E, WA3M, WA3W  in  4  destination register in E/M/W
- RegWriteM, RegWriteW  in  1  destination write enables
- MemtoRegE  in  1  load in Execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-write pending per stage
- BranchTakenE  in  1  branch resolved taken in Execute
- MemReqM  in  1  data access in Memory (MemtoRegM | MemWriteM)
- MemReadyM  in  1  data memory ready/complete
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- StallF, StallD, StallE, StallM  out  1  hold enables
- FlushD, FlushE, FlushW  out  1  bubble inserts
- MemTimeout  out  1  one-cycle pulse on forced release
- MemErr  out  1  sticky timeout flag

## Operation
- Forwarding (A shown, B identical with RA2E): 10 if RegWriteM & WA3M==RA1E; else 01 if RegWriteW & WA3W==RA1E; else 00. RA==4'hF never forwards.
- ldrStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Normal (IDLE, no memstall): StallF = ldrStall | PCWrPendingF; StallD = ldrStall; StallE = StallM = 0; FlushD = PCWrPendingF | PCSrcW | BranchTakenE; FlushE = ldrStall | BranchTakenE; FlushW = 0.
- memstall = (state==IDLE & MemReqM & ~MemReadyM) | (state==WAIT & ~MemReadyM & ~expire).
- memstall dominates: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0; hazard stalls/flushes re-evaluated after release.
- FSM states IDLE, WAIT:
  - IDLE -> WAIT: MemReqM & ~MemReadyM; counter loads 1.
  - WAIT -> IDLE: MemReadyM, or expire (counter == MEM_TIMEOUT).
  - WAIT, no event: counter increments.
- expire: MemTimeout=1 that cycle, MemErr set, pipeline released (stall outputs low, as if ready).
- MemReqM & MemReadyM in IDLE: zero-cycle access, no stall, stay IDLE.
- MemErr cleared only by reset.

## Timing
- Forwarding, stall, flush outputs combinational from inputs and current state; zero latency.
- State, counter, MemErr registered; MemTimeout combinational from state/counter.
- Reset (reset=0): state IDLE, counter 0, MemErr 0; hence MemTimeout 0, all memstall terms 0. Reset mid-WAIT aborts the wait immediately.
- A wait with MemReadyM first high at cycle k after request stalls exactly k cycles.
- Timeout: release in the cycle counter==MEM_TIMEOUT, i.e. MEM_TIMEOUT stall cycles total.

## Configuration
- PIPE_PERF_CNT_EN: when defined, adds outputs StallCnt[31:0] (cycles with StallF=1) and FlushCnt[31:0] (cycles with FlushD|FlushE|FlushW), saturating at 32'hFFFFFFFF, reset to 0. When undefined, ports and logic absent; remaining behaviour identical.

## Structure
- Shared package: FSM state encoding (IDLE=0, WAIT=1), forwarding select constants FWD_RF/FWD_W/FWD_M, PC register index 4'hF.
- One sub-module: pipeline_fwd_unit (pure combinational forwarding compare, instantiated twice for A/B).

## Test plan
- WA3M=3, RegWriteM=1, RA1E=3, also WA3W=3 RegWriteW=1 -> ForwardAE=10 (M priority); RA1E=4'hF -> 00.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 one cycle, StallE=0.
- BranchTakenE=1 -> FlushD=FlushE=1; PCSrcD=1 -> StallF=FlushD=1.
- MemReqM=1, MemReadyM high after 3 cycles -> StallF..StallM and FlushW high exactly 3 cycles, state back to IDLE, MemErr=0.
- MemReqM=1, MemReadyM never high, MEM_TIMEOUT=16 -> release after 16 stall cycles, MemTimeout one pulse, MemErr stays 1 until reset=0.
- Assert reset=0 during WAIT -> stalls drop asynchronously, MemErr=0; with PIPE_PERF_CNT_EN counters read 0.
